inst_queue: RTL and testbench

Parametrised dual-port instruction queue between IF and ID, replacing the fixed 4-entry IF/ID instruction buffer. IF writes up to two fetched instructions per cycle into a circular buffer of DEPTH entries. ID sees the two oldest entries and consumes zero, one or two per cycle. The queue decides combinationally whether the second head entry may issue alongside the first, and supports a single-cycle flush on redirect.

---
 rtl/inst_queue_pkg.sv | 42 ++++
 rtl/iq_pair_check.sv | 53 +++++
 rtl/inst_queue.sv | 188 ++++++++++++++++++
 tb/tb_inst_queue.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared constants for the IF/ID instruction queue: bus widths, memory opcodes
// and the packed entry layout {isbranch, taken, pc, npc, inst} (inst at LSB).
package inst_queue_pkg;

  localparam int PC_BUS   = 32;
  localparam int INST_BUS = 32;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Offsets are functions of the widths so non-default PC_W/INST_W stay consistent.
  function automatic int ent_off_npc(input int inst_w);
    return inst_w;
  endfunction

  function automatic int ent_off_pc(input int inst_w, input int pc_w);
    return inst_w + pc_w;
  endfunction

  function automatic int ent_off_taken(input int inst_w, input int pc_w);
    return inst_w + 2 * pc_w;
  endfunction

  function automatic int ent_off_isbr(input int inst_w, input int pc_w);
    return inst_w + 2 * pc_w + 1;
  endfunction

  function automatic int ent_width(input int inst_w, input int pc_w);
    return inst_w + 2 * pc_w + 2;
  endfunction

  localparam int ENT_INST  = 0;
  localparam int ENT_NPC   = INST_BUS;
  localparam int ENT_PC    = INST_BUS + PC_BUS;
  localparam int ENT_TAKEN = INST_BUS + 2 * PC_BUS;
  localparam int ENT_ISBR  = INST_BUS + 2 * PC_BUS + 1;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/iq_pair_check.sv
// Combinational dual-issue check on the two oldest queue entries; decides
// whether slot 2 may issue alongside slot 1.
module iq_pair_check
  import inst_queue_pkg::*;
#(
  parameter int PC_W   = PC_BUS,
  parameter int INST_W = INST_BUS,
  parameter int CNT_W  = 4
) (
  input  logic [ent_width(INST_W, PC_W)-1:0] ent1_i,
  input  logic [ent_width(INST_W, PC_W)-1:0] ent2_i,
  input  logic [CNT_W-1:0]                   count_i,
  output logic                               out1_valid_o,
  output logic                               out2_valid_o
);

  localparam int E_TAKEN = ent_off_taken(INST_W, PC_W);
  localparam int E_ISBR  = ent_off_isbr(INST_W, PC_W);

  logic       br1, tk1, br2;
  logic [6:0] op1, op2;
  logic       unused_ent_bits;

  assign br1 = ent1_i[E_ISBR];
  assign tk1 = ent1_i[E_TAKEN];
  assign br2 = ent2_i[E_ISBR];
  assign op1 = ent1_i[6:0];
  assign op2 = ent2_i[6:0];
  assign unused_ent_bits = ^{ent1_i, ent2_i};

  // First matching rule wins; only the final fall-through pairs the slots.
  always_comb begin
    out1_valid_o = 1'b0;
    out2_valid_o = 1'b0;
    if (count_i == '0) begin
      out1_valid_o = 1'b0;
    end else if (count_i == CNT_W'(1)) begin
      out1_valid_o = 1'b1;
    end else begin
      out1_valid_o = 1'b1;
      if (br1 && tk1) begin
        out2_valid_o = 1'b0;
      end else if (br1 && br2) begin
        out2_valid_o = 1'b0;
      end else if (is_mem_op(op1) && is_mem_op(op2)) begin
        out2_valid_o = 1'b0;
      end else begin
        out2_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_queue.sv
// Dual-port circular IF/ID instruction queue with pairing check and flush.
// Optional INST_QUEUE_PERF_EN adds saturating pairing-stall and full counters.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PC_W   = PC_BUS,
  parameter int INST_W = INST_BUS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [1:0]              in_valid,
  input  logic [INST_W-1:0]       in1_inst,
  input  logic [INST_W-1:0]       in2_inst,
  input  logic [PC_W-1:0]         in1_pc,
  input  logic [PC_W-1:0]         in2_pc,
  input  logic [PC_W-1:0]         in1_npc,
  input  logic [PC_W-1:0]         in2_npc,
  input  logic                    in1_isbranch,
  input  logic                    in2_isbranch,
  input  logic                    in1_taken,
  input  logic                    in2_taken,
  output logic                    in_ready,
  output logic                    out1_valid,
  output logic                    out2_valid,
  output logic [INST_W-1:0]       out1_inst,
  output logic [INST_W-1:0]       out2_inst,
  output logic [PC_W-1:0]         out1_pc,
  output logic [PC_W-1:0]         out2_pc,
  output logic [PC_W-1:0]         out1_npc,
  output logic [PC_W-1:0]         out2_npc,
  input  logic [1:0]              deq,
  output logic [$clog2(DEPTH):0]  count
`ifdef INST_QUEUE_PERF_EN
  ,
  output logic [31:0]             perf_single_issue,
  output logic [31:0]             perf_full
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EW    = ent_width(INST_W, PC_W);
  localparam int E_NPC = ent_off_npc(INST_W);
  localparam int E_PC  = ent_off_pc(INST_W, PC_W);

  logic [EW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [EW-1:0]    ent1, ent2, new1, new2, wr0_data, wr1_data;
  logic             wr0_en, wr1_en;
  logic [1:0]       n_wr, n_req, n_avail, n_deq;
  logic [PTR_W-1:0] tail_p1;

  // Handshake: IF may assert in_valid only while in_ready is high (two free
  // entries at cycle start); ID may consume via deq only slots whose outN_valid
  // is high. Violations are absorbed: writes dropped, consumption clamped.
  assign in_ready = (count_q <= CNT_W'(DEPTH - 2));
  assign count    = count_q;

  assign ent1    = mem_q[head_q];
  assign ent2    = mem_q[head_q + PTR_W'(1)];
  assign tail_p1 = tail_q + PTR_W'(1);

  assign new1 = {in1_isbranch, in1_taken, in1_pc, in1_npc, in1_inst};
  assign new2 = {in2_isbranch, in2_taken, in2_pc, in2_npc, in2_inst};

  iq_pair_check #(
    .PC_W   (PC_W),
    .INST_W (INST_W),
    .CNT_W  (CNT_W)
  ) u_pair_check (
    .ent1_i       (ent1),
    .ent2_i       (ent2),
    .count_i      (count_q),
    .out1_valid_o (out1_valid),
    .out2_valid_o (out2_valid)
  );

  assign out1_inst = out1_valid ? ent1[0 +: INST_W]   : '0;
  assign out1_npc  = out1_valid ? ent1[E_NPC +: PC_W] : '0;
  assign out1_pc   = out1_valid ? ent1[E_PC +: PC_W]  : '0;
  assign out2_inst = out2_valid ? ent2[0 +: INST_W]   : '0;
  assign out2_npc  = out2_valid ? ent2[E_NPC +: PC_W] : '0;
  assign out2_pc   = out2_valid ? ent2[E_PC +: PC_W]  : '0;

  // A predicted-taken in1 makes in2 wrong-path, so it is never written.
  always_comb begin
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    wr0_data = new1;
    wr1_data = new2;
    n_wr     = 2'd0;
    if (in_ready && !flush) begin
      unique case (in_valid)
        2'b01: begin
          wr0_en = 1'b1;
          n_wr   = 2'd1;
        end
        2'b10: begin
          wr0_en   = 1'b1;
          wr0_data = new2;
          n_wr     = 2'd1;
        end
        2'b11: begin
          wr0_en = 1'b1;
          if (in1_isbranch && in1_taken) begin
            n_wr = 2'd1;
          end else begin
            wr1_en = 1'b1;
            n_wr   = 2'd2;
          end
        end
        default: begin
          n_wr = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    n_req   = {1'b0, deq[0]} + {1'b0, deq[1]};
    n_avail = {1'b0, out1_valid} + {1'b0, out2_valid};
    n_deq   = (n_req > n_avail) ? n_avail : n_req;
    head_d  = head_q + PTR_W'(n_deq);
    tail_d  = tail_q + PTR_W'(n_wr);
    count_d = count_q + CNT_W'(n_wr) - CNT_W'(n_deq);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr0_en) begin
        mem_q[tail_q] <= wr0_data;
      end
      if (wr1_en) begin
        mem_q[tail_p1] <= wr1_data;
      end
    end
  end

`ifdef INST_QUEUE_PERF_EN
  logic [31:0] perf_single_q, perf_full_q;
  logic        pair_stall;

  assign pair_stall        = out1_valid && !out2_valid && (count_q >= CNT_W'(2));
  assign perf_single_issue = perf_single_q;
  assign perf_full         = perf_full_q;

  // Counters survive flush so they span redirects; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_single_q <= '0;
      perf_full_q   <= '0;
    end else begin
      if (pair_stall && (perf_single_q != '1)) begin
        perf_single_q <= perf_single_q + 32'd1;
      end
      if (!in_ready && (perf_full_q != '1)) begin
        perf_full_q <= perf_full_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed and randomized bench for inst_queue against a queue-based model
// of the FIFO, pairing rules, flush and reset behaviour.
module tb_inst_queue;

  localparam int DEPTH  = 8;
  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam int W      = 2 + 2 * PC_W + INST_W;
  localparam int B_BR   = 97;
  localparam int B_TK   = 96;

  localparam logic [6:0] OPC_ALU = 7'b0110011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;

  logic              clk, rst, flush;
  logic [1:0]        in_valid, deq;
  logic [INST_W-1:0] in1_inst, in2_inst;
  logic [PC_W-1:0]   in1_pc, in2_pc, in1_npc, in2_npc;
  logic              in1_isbranch, in2_isbranch, in1_taken, in2_taken;
  logic              in_ready, out1_valid, out2_valid;
  logic [INST_W-1:0] out1_inst, out2_inst;
  logic [PC_W-1:0]   out1_pc, out2_pc, out1_npc, out2_npc;
  logic [3:0]        count;
`ifdef INST_QUEUE_PERF_EN
  logic [31:0]       perf_single_issue, perf_full;
`endif

  inst_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in1_inst     (in1_inst),
    .in2_inst     (in2_inst),
    .in1_pc       (in1_pc),
    .in2_pc       (in2_pc),
    .in1_npc      (in1_npc),
    .in2_npc      (in2_npc),
    .in1_isbranch (in1_isbranch),
    .in2_isbranch (in2_isbranch),
    .in1_taken    (in1_taken),
    .in2_taken    (in2_taken),
    .in_ready     (in_ready),
    .out1_valid   (out1_valid),
    .out2_valid   (out2_valid),
    .out1_inst    (out1_inst),
    .out2_inst    (out2_inst),
    .out1_pc      (out1_pc),
    .out2_pc      (out2_pc),
    .out1_npc     (out1_npc),
    .out2_npc     (out2_npc),
    .deq          (deq),
    .count        (count)
`ifdef INST_QUEUE_PERF_EN
    ,
    .perf_single_issue (perf_single_issue),
    .perf_full         (perf_full)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [6:0] op, input logic br, input logic tk,
                                      input logic [31:0] pc);
    logic [31:0] inst, npc;
    inst = {$urandom_range(0, 32'h1ff_ffff), 7'b0} | {25'd0, op};
    npc  = tk ? $urandom() : pc + 32'd4;
    return {br, tk, pc, npc, inst};
  endfunction

  function automatic logic [W-1:0] rand_ent(input logic [31:0] pc);
    case ($urandom_range(0, 3))
      0:       return mk(OPC_ALU, 1'b0, 1'b0, pc);
      1:       return mk(OPC_LD, 1'b0, 1'b0, pc);
      2:       return mk(OPC_ST, 1'b0, 1'b0, pc);
      default: return mk(OPC_BR, 1'b1, 1'($urandom_range(0, 1)), pc);
    endcase
  endfunction

  function automatic logic is_mem(input logic [W-1:0] e);
    return (e[6:0] == OPC_LD) || (e[6:0] == OPC_ST);
  endfunction

  // Returns {slot2_valid, slot1_valid} from the model's two oldest entries.
  function automatic logic [1:0] exp_valid();
    logic [W-1:0] e1, e2;
    if (exp_q.size() == 0) return 2'b00;
    if (exp_q.size() == 1) return 2'b01;
    e1 = exp_q[0];
    e2 = exp_q[1];
    if (e1[B_BR] && e1[B_TK]) return 2'b01;
    if (e1[B_BR] && e2[B_BR]) return 2'b01;
    if (is_mem(e1) && is_mem(e2)) return 2'b01;
    return 2'b11;
  endfunction

  task automatic check_outputs(input string where);
    logic [1:0]   v;
    logic [W-1:0] e1, e2;
    v  = exp_valid();
    e1 = (v[0]) ? exp_q[0] : '0;
    e2 = (v[1]) ? exp_q[1] : '0;
    chk({where, ".count"}, 64'(count), 64'(exp_q.size()));
    chk({where, ".in_ready"}, 64'(in_ready), 64'(exp_q.size() <= DEPTH - 2));
    chk({where, ".out1_valid"}, 64'(out1_valid), 64'(v[0]));
    chk({where, ".out2_valid"}, 64'(out2_valid), 64'(v[1]));
    chk({where, ".out1_inst"}, 64'(out1_inst), 64'(e1[31:0]));
    chk({where, ".out1_npc"}, 64'(out1_npc), 64'(e1[63:32]));
    chk({where, ".out1_pc"}, 64'(out1_pc), 64'(e1[95:64]));
    chk({where, ".out2_inst"}, 64'(out2_inst), 64'(e2[31:0]));
    chk({where, ".out2_npc"}, 64'(out2_npc), 64'(e2[63:32]));
    chk({where, ".out2_pc"}, 64'(out2_pc), 64'(e2[95:64]));
  endtask

  task automatic model_step(input logic [1:0] iv, input logic [W-1:0] e1, input logic [W-1:0] e2,
                            input logic [1:0] dq, input logic fl);
    logic [1:0] v;
    int avail, req, pop;
    bit ready;
    if (fl) begin
      exp_q.delete();
      return;
    end
    ready = (exp_q.size() <= DEPTH - 2);
    v     = exp_valid();
    avail = int'(v[0]) + int'(v[1]);
    req   = int'(dq[0]) + int'(dq[1]);
    pop   = (req > avail) ? avail : req;
    repeat (pop) void'(exp_q.pop_front());
    if (ready) begin
      if (iv == 2'b01) exp_q.push_back(e1);
      if (iv == 2'b10) exp_q.push_back(e2);
      if (iv == 2'b11) begin
        exp_q.push_back(e1);
        if (!(e1[B_BR] && e1[B_TK])) exp_q.push_back(e2);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    flush = 1'b0; in_valid = 2'b00; deq = 2'b00;
    {in1_isbranch, in1_taken, in1_pc, in1_npc, in1_inst} = '0;
    {in2_isbranch, in2_taken, in2_pc, in2_npc, in2_inst} = '0;
  endtask

  // Called at posedge+1: checks current outputs, drives one cycle, advances model.
  task automatic drive(input string where, input logic [1:0] iv, input logic [W-1:0] e1,
                       input logic [W-1:0] e2, input logic [1:0] dq, input logic fl);
    check_outputs(where);
    in_valid = iv; deq = dq; flush = fl;
    {in1_isbranch, in1_taken, in1_pc, in1_npc, in1_inst} = e1;
    {in2_isbranch, in2_taken, in2_pc, in2_npc, in2_inst} = e2;
    model_step(iv, e1, e2, dq, fl);
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] a, b, c;
    logic [31:0]  pc;
    logic [1:0]   iv, dq, v;
    logic         fl;

    do_reset();
    check_outputs("reset");
    chk("reset.in_ready_const", 64'(in_ready), 64'd1);

    // Two ALU ops pair and drain together.
    a = mk(OPC_ALU, 1'b0, 1'b0, 32'h100);
    b = mk(OPC_ALU, 1'b0, 1'b0, 32'h104);
    drive("alu_pair.enq", 2'b11, a, b, 2'b00, 1'b0);
    chk("alu_pair.count", 64'(count), 64'd2);
    chk("alu_pair.out1_pc", 64'(out1_pc), 64'h100);
    chk("alu_pair.out2_pc", 64'(out2_pc), 64'h104);
    chk("alu_pair.both_valid", 64'({out1_valid, out2_valid}), 64'b11);
    drive("alu_pair.deq", 2'b00, '0, '0, 2'b11, 1'b0);
    chk("alu_pair.drained", 64'(count), 64'd0);

    // Two loads must not pair.
    a = mk(OPC_LD, 1'b0, 1'b0, 32'h200);
    b = mk(OPC_LD, 1'b0, 1'b0, 32'h204);
    drive("loads.enq", 2'b11, a, b, 2'b00, 1'b0);
    chk("loads.out2_valid", 64'(out2_valid), 64'd0);
    drive("loads.deq1", 2'b00, '0, '0, 2'b01, 1'b0);
    chk("loads.second_head", 64'(out1_pc), 64'h204);
    chk("loads.single_left", 64'(out2_valid), 64'd0);
    drive("loads.drain", 2'b00, '0, '0, 2'b01, 1'b0);

    // Predicted-taken in1 discards in2 and blocks pairing.
    a = mk(OPC_BR, 1'b1, 1'b1, 32'h300);
    b = mk(OPC_ALU, 1'b0, 1'b0, 32'h304);
    c = mk(OPC_ALU, 1'b0, 1'b0, 32'h400);
    drive("taken.enq", 2'b11, a, b, 2'b00, 1'b0);
    chk("taken.count", 64'(count), 64'd1);
    drive("taken.enq2", 2'b01, c, '0, 2'b00, 1'b0);
    chk("taken.count2", 64'(count), 64'd2);
    chk("taken.out2_valid", 64'(out2_valid), 64'd0);
    chk("taken.out1_pc", 64'(out1_pc), 64'h300);
    drive("taken.drain1", 2'b00, '0, '0, 2'b01, 1'b0);
    drive("taken.drain2", 2'b00, '0, '0, 2'b01, 1'b0);

    // Fill to full, then stream through pointer wrap.
    pc = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      a = mk(OPC_ALU, 1'b0, 1'b0, pc);
      b = mk(OPC_ALU, 1'b0, 1'b0, pc + 32'd4);
      pc += 32'd8;
      drive("fill", 2'b11, a, b, 2'b00, 1'b0);
    end
    chk("full.count", 64'(count), 64'd8);
    chk("full.in_ready8", 64'(in_ready), 64'd0);
    drive("full.deq1", 2'b00, '0, '0, 2'b01, 1'b0);
    chk("full.count7", 64'(count), 64'd7);
    chk("full.in_ready7", 64'(in_ready), 64'd0);
    for (int i = 0; i < 20; i++) begin
      a = mk(OPC_ALU, 1'b0, 1'b0, pc);
      b = mk(OPC_ALU, 1'b0, 1'b0, pc + 32'd4);
      pc += 32'd8;
      drive("wrap", 2'b11, a, b, 2'b11, 1'b0);
    end

    // Flush beats simultaneous enqueue and dequeue.
    drive("flush.clear", 2'b00, '0, '0, 2'b00, 1'b1);
    for (int i = 0; i < 2; i++) begin
      a = mk(OPC_ALU, 1'b0, 1'b0, pc);
      b = mk(OPC_ALU, 1'b0, 1'b0, pc + 32'd4);
      pc += 32'd8;
      drive("flush.fill", 2'b11, a, b, 2'b00, 1'b0);
    end
    drive("flush.fill1", 2'b01, mk(OPC_ALU, 1'b0, 1'b0, pc), '0, 2'b00, 1'b0);
    chk("flush.count5", 64'(count), 64'd5);
    drive("flush.go", 2'b11, mk(OPC_ALU, 1'b0, 1'b0, 32'h500),
          mk(OPC_ALU, 1'b0, 1'b0, 32'h504), 2'b11, 1'b1);
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.valids", 64'({out1_valid, out2_valid}), 64'b00);
    chk("flush.in_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset mid-cycle at count 6.
    for (int i = 0; i < 3; i++) begin
      a = mk(OPC_ALU, 1'b0, 1'b0, pc);
      b = mk(OPC_ALU, 1'b0, 1'b0, pc + 32'd4);
      pc += 32'd8;
      drive("areset.fill", 2'b11, a, b, 2'b00, 1'b0);
    end
    chk("areset.count6", 64'(count), 64'd6);
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    chk("areset.count", 64'(count), 64'd0);
    chk("areset.out1_valid", 64'(out1_valid), 64'd0);
    chk("areset.in_ready", 64'(in_ready), 64'd1);
    chk("areset.out1_pc", 64'(out1_pc), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    a = mk(OPC_ALU, 1'b0, 1'b0, 32'h700);
    b = mk(OPC_LD, 1'b0, 1'b0, 32'h704);
    drive("areset.enq", 2'b11, a, b, 2'b00, 1'b0);
    chk("areset.count2", 64'(count), 64'd2);
    chk("areset.head_pc", 64'(out1_pc), 64'h700);

    // Randomized traffic with occasional protocol violations and flushes.
    for (int i = 0; i < 400; i++) begin
      a  = rand_ent(pc);
      b  = rand_ent(pc + 32'd4);
      pc += 32'd8;
      iv = 2'($urandom_range(0, 3));
      if (exp_q.size() > DEPTH - 2 && $urandom_range(0, 3) != 0) iv = 2'b00;
      v = exp_valid();
      case ($urandom_range(0, 2))
        0:       dq = 2'b00;
        1:       dq = v[0] ? 2'b01 : 2'b00;
        default: dq = (v[1] || $urandom_range(0, 7) == 0) ? 2'b11 : 2'b01;
      endcase
      fl = ($urandom_range(0, 31) == 0);
      drive("rand", iv, a, b, dq, fl);
    end
    check_outputs("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
